// File: rtl/rv32i_single_cycle_top.sv
`default_nettype none
// =============================================================================
// Module   : rv32i_single_cycle_top
// Brief    : Single-cycle RV32I core with IMEM, register file, ALU and DMEM.
//            Define RISCV_HALT_EN to make ECALL/EBREAK halt the core.
// Revision : 1.0
// =============================================================================

module rv32i_imem #(
    parameter int IMEM_WORDS = 32
) (
    input  wire logic                          i_clock,
    input  wire logic [31:0]                   i_pc,
    input  wire logic                          i_wr_en,
    input  wire logic [$clog2(IMEM_WORDS)-1:0] i_wr_addr,
    input  wire logic [31:0]                   i_wr_data,
    output logic      [31:0]                   o_instr
);
    localparam int IAW = $clog2(IMEM_WORDS);

    logic [IAW-1:0] w_idx;
    logic           w_unused;

    // Word storage; the write port is tied off at the top and images are loaded from outside.
    if (1) begin : WORD
        logic [31:0] MEM [0:IMEM_WORDS-1];
        always @(posedge i_clock) begin
            if (i_wr_en) MEM[i_wr_addr] <= i_wr_data;
        end
    end

    if (1) begin : BYTE
        logic [7:0] MEM [0:4*IMEM_WORDS-1];
        for (genvar g = 0; g < 4*IMEM_WORDS; g++) begin : g_lane
            assign MEM[g] = WORD.MEM[g/4][8*(g%4) +: 8];
        end
    end

    assign w_idx    = i_pc[IAW+1:2];
    assign o_instr  = {BYTE.MEM[{w_idx, 2'd3}], BYTE.MEM[{w_idx, 2'd2}],
                       BYTE.MEM[{w_idx, 2'd1}], BYTE.MEM[{w_idx, 2'd0}]};
    assign w_unused = ^{i_pc[31:IAW+2], i_pc[1:0]};
endmodule

module rv32i_dmem #(
    parameter int DMEM_WORDS = 64
) (
    input  wire logic                          i_clock,
    input  wire logic [$clog2(DMEM_WORDS)-1:0] i_widx,
    input  wire logic [3:0]                    i_be,
    input  wire logic [31:0]                   i_wdata,
    output logic      [31:0]                   o_rdata
);
    logic [31:0] DMEM [0:DMEM_WORDS-1];

    always_ff @(posedge i_clock) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) DMEM[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign o_rdata = DMEM[i_widx];
endmodule

module rv32i_idecode (
    input  wire logic        i_clock,
    input  wire logic        i_reset,
    input  wire logic [31:0] i_instr,
    input  wire logic        i_rd_we,
    input  wire logic [31:0] i_rd_data,
    output logic      [6:0]  o_opcode,
    output logic      [2:0]  o_funct3,
    output logic      [6:0]  o_funct7,
    output logic      [31:0] o_rs1_data,
    output logic      [31:0] o_rs2_data,
    output logic      [31:0] o_imm
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;

    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;

    assign o_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign o_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign o_funct7 = i_instr[31:25];

    if (1) begin : RF
        logic [31:0] R [0:31];
        always_ff @(posedge i_clock) begin
            if (!i_reset) begin
                for (int i = 0; i < 32; i++) R[i] <= '0;
            end else if (i_rd_we && (w_rd != 5'd0)) begin
                R[w_rd] <= i_rd_data;
            end
        end
    end

    assign o_rs1_data = (w_rs1 == 5'd0) ? '0 : RF.R[w_rs1];
    assign o_rs2_data = (w_rs2 == 5'd0) ? '0 : RF.R[w_rs2];

    always_comb begin
        o_imm = {{21{i_instr[31]}}, i_instr[30:20]};
        case (o_opcode)
            c_OP_LUI, c_OP_AUIPC: o_imm = {i_instr[31:12], 12'h000};
            c_OP_JAL:    o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            c_OP_BRANCH: o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            c_OP_STORE:  o_imm = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
            default: ;
        endcase
    end
endmodule

module rv32i_single_cycle_top #(
    parameter int          IMEM_WORDS = 32,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input wire logic i_clock,
    input wire logic i_reset
);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    logic [31:0] r_pc;
    logic [31:0] w_instr, w_rs1, w_rs2, w_imm, w_alu_b, w_alu, w_sra, w_addr;
    logic [31:0] w_rword, w_load, w_rd_data, w_next_pc, w_pc4, w_st_data;
    logic [15:0] w_lhalf;
    logic [7:0]  w_lbyte;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_shamt;
    logic [3:0]  w_be;
    logic [2:0]  w_funct3;
    logic        w_rd_ok, w_cond, w_run, w_sub, w_rf_we, w_unused;

    rv32i_imem #(.IMEM_WORDS(IMEM_WORDS)) u_imem (
        .i_clock   (i_clock),
        .i_pc      (r_pc),
        .i_wr_en   (1'b0),
        .i_wr_addr ('0),
        .i_wr_data ('0),
        .o_instr   (w_instr)
    );

    rv32i_idecode u_idecode (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_instr    (w_instr),
        .i_rd_we    (w_rf_we),
        .i_rd_data  (w_rd_data),
        .o_opcode   (w_opcode),
        .o_funct3   (w_funct3),
        .o_funct7   (w_funct7),
        .o_rs1_data (w_rs1),
        .o_rs2_data (w_rs2),
        .o_imm      (w_imm)
    );

    rv32i_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
        .i_clock (i_clock),
        .i_widx  (w_addr[DAW+1:2]),
        .i_be    ((i_reset && w_run) ? w_be : 4'b0000),
        .i_wdata (w_st_data),
        .o_rdata (w_rword)
    );

    assign w_pc4    = r_pc + 32'd4;
    assign w_addr   = w_rs1 + w_imm;
    assign w_rf_we  = w_rd_ok && w_run && i_reset;
    assign w_unused = ^w_addr[31:DAW+2];

    always_comb begin
        w_sub   = (w_opcode == c_OP_OP) && w_funct7[5];
        w_alu_b = (w_opcode == c_OP_OP) ? w_rs2 : w_imm;
        w_shamt = w_alu_b[4:0];
        w_sra   = $signed(w_rs1) >>> w_shamt;
        case (w_funct3)
            3'b000:  w_alu = w_sub ? (w_rs1 - w_alu_b) : (w_rs1 + w_alu_b);
            3'b001:  w_alu = w_rs1 << w_shamt;
            3'b010:  w_alu = {31'b0, $signed(w_rs1) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'b0, w_rs1 < w_alu_b};
            3'b100:  w_alu = w_rs1 ^ w_alu_b;
            3'b101:  w_alu = w_funct7[5] ? w_sra : (w_rs1 >> w_shamt);
            3'b110:  w_alu = w_rs1 | w_alu_b;
            default: w_alu = w_rs1 & w_alu_b;
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_cond = (w_rs1 == w_rs2);
            3'b001:  w_cond = (w_rs1 != w_rs2);
            3'b100:  w_cond = ($signed(w_rs1) <  $signed(w_rs2));
            3'b101:  w_cond = ($signed(w_rs1) >= $signed(w_rs2));
            3'b110:  w_cond = (w_rs1 <  w_rs2);
            3'b111:  w_cond = (w_rs1 >= w_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    // Sub-word lanes come straight from the low address bits, which also aligns misaligned accesses down.
    always_comb begin
        w_lbyte = w_rword[{w_addr[1:0], 3'b000} +: 8];
        w_lhalf = w_rword[{w_addr[1], 4'b0000} +: 16];
        case (w_funct3)
            3'b000:  w_load = {{24{w_lbyte[7]}}, w_lbyte};
            3'b001:  w_load = {{16{w_lhalf[15]}}, w_lhalf};
            3'b100:  w_load = {24'b0, w_lbyte};
            3'b101:  w_load = {16'b0, w_lhalf};
            default: w_load = w_rword;
        endcase
    end

    always_comb begin
        w_rd_ok   = 1'b0;
        w_rd_data = w_alu;
        w_next_pc = w_pc4;
        w_be      = 4'b0000;
        w_st_data = w_rs2;
        case (w_opcode)
            c_OP_LUI:   begin w_rd_ok = 1'b1; w_rd_data = w_imm; end
            c_OP_AUIPC: begin w_rd_ok = 1'b1; w_rd_data = r_pc + w_imm; end
            c_OP_JAL:   begin w_rd_ok = 1'b1; w_rd_data = w_pc4; w_next_pc = r_pc + w_imm; end
            c_OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_rd_ok   = 1'b1;
                    w_rd_data = w_pc4;
                    w_next_pc = {w_addr[31:1], 1'b0};
                end
            end
            c_OP_BRANCH: if (w_cond) w_next_pc = r_pc + w_imm;
            c_OP_LOAD: begin
                w_rd_data = w_load;
                w_rd_ok   = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            end
            c_OP_STORE: begin
                case (w_funct3)
                    3'b000: begin w_be = 4'b0001 << w_addr[1:0]; w_st_data = {4{w_rs2[7:0]}}; end
                    3'b001: begin w_be = w_addr[1] ? 4'b1100 : 4'b0011; w_st_data = {2{w_rs2[15:0]}}; end
                    3'b010: w_be = 4'b1111;
                    default: ;
                endcase
            end
            c_OP_OPIMM: begin
                if (w_funct3 == 3'b001)      w_rd_ok = (w_funct7 == 7'h00);
                else if (w_funct3 == 3'b101) w_rd_ok = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                else                         w_rd_ok = 1'b1;
            end
            c_OP_OP: w_rd_ok = (w_funct7 == 7'h00) ||
                               ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            default: ;
        endcase
    end

`ifdef RISCV_HALT_EN
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    logic r_halted;
    logic w_sys;

    // ECALL/EBREAK: imm 0 or 1 with rs1, funct3 and rd all zero; the PC parks on the trapping instruction.
    assign w_sys = (w_opcode == c_OP_SYSTEM) && (w_imm[31:1] == 31'b0) && (w_instr[19:7] == 13'b0);
    assign w_run = !r_halted && !w_sys;

    always_ff @(posedge i_clock) begin
        if (!i_reset)   r_halted <= 1'b0;
        else if (w_sys) r_halted <= 1'b1;
    end
`else
    assign w_run = 1'b1;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset)   r_pc <= RESET_PC;
        else if (w_run) r_pc <= w_next_pc;
    end
endmodule

`default_nettype wire

// File: tb/tb_rv32i_single_cycle_top.sv
`default_nettype none
// Directed-program bench for rv32i_single_cycle_top with an instruction-level reference model.
module tb_rv32i_single_cycle_top;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cmp_bad;

    logic [31:0] m_imem [0:31];
    logic [31:0] m_x    [0:31];
    logic [7:0]  m_mem  [0:255];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    rv32i_single_cycle_top u_dut (
        .i_clock (clk),
        .i_reset (rst_n)
    );

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    // Instruction-set level model: decode by mnemonic, memory as a flat byte array.
    task automatic model_step();
        logic [31:0] in, a, b, ii, is, ib, iu, ij, nxt, wd;
        logic [7:0]  ea;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        wr;
        in = m_imem[m_pc[6:2]];
        f3 = in[14:12]; f7 = in[31:25];
        a  = m_x[in[19:15]]; b = m_x[in[24:20]];
        ii = {{20{in[31]}}, in[31:20]};
        is = {{20{in[31]}}, in[31:25], in[11:7]};
        ib = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        iu = {in[31:12], 12'h000};
        ij = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        nxt = m_pc + 4; wr = 1'b0; wd = 32'h0;
        case (in[6:0])
            7'h37: begin wr = 1'b1; wd = iu; end
            7'h17: begin wr = 1'b1; wd = m_pc + iu; end
            7'h6F: begin wr = 1'b1; wd = m_pc + 4; nxt = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin wr = 1'b1; wd = m_pc + 4; nxt = (a + ii) & ~32'h1; end
            7'h63: begin
                if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b) ||
                    (f3 == 3'd4 && $signed(a) < $signed(b)) || (f3 == 3'd5 && $signed(a) >= $signed(b)) ||
                    (f3 == 3'd6 && a < b) || (f3 == 3'd7 && a >= b))
                    nxt = m_pc + ib;
            end
            7'h03: begin
                ea = 8'(a + ii);
                wr = 1'b1;
                case (f3)
                    3'd0: wd = {{24{m_mem[ea][7]}}, m_mem[ea]};
                    3'd4: wd = {24'h0, m_mem[ea]};
                    3'd1: wd = {{16{m_mem[ea|8'h1][7]}}, m_mem[ea|8'h1], m_mem[ea & 8'hFE]};
                    3'd5: wd = {16'h0, m_mem[ea|8'h1], m_mem[ea & 8'hFE]};
                    3'd2: wd = {m_mem[ea|8'h3], m_mem[(ea & 8'hFC)|8'h2], m_mem[(ea & 8'hFC)|8'h1], m_mem[ea & 8'hFC]};
                    default: wr = 1'b0;
                endcase
            end
            7'h23: begin
                ea = 8'(a + is);
                if (f3 == 3'd0) m_mem[ea] = b[7:0];
                if (f3 == 3'd1) begin m_mem[ea & 8'hFE] = b[7:0]; m_mem[ea | 8'h1] = b[15:8]; end
                if (f3 == 3'd2) for (int k = 0; k < 4; k++) m_mem[(ea & 8'hFC) + 8'(k)] = b[8*k +: 8];
            end
            7'h13, 7'h33: begin
                logic [31:0] y;
                logic        rtype;
                rtype = (in[6:0] == 7'h33);
                y = rtype ? b : ii;
                wr = 1'b1;
                case (f3)
                    3'd0: wd = (rtype && f7 == 7'h20) ? a - y : a + y;
                    3'd1: wd = a << y[4:0];
                    3'd2: wd = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: wd = (a < y) ? 32'd1 : 32'd0;
                    3'd4: wd = a ^ y;
                    3'd5: if (f7 == 7'h20) wd = $signed(a) >>> y[4:0]; else wd = a >> y[4:0];
                    3'd6: wd = a | y;
                    default: wd = a & y;
                endcase
                if (rtype && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) wr = 1'b0;
                if (!rtype && f3 == 3'd1 && f7 != 7'h00) wr = 1'b0;
                if (!rtype && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) wr = 1'b0;
            end
            default: ;
        endcase
        if (wr && in[11:7] != 5'd0) m_x[in[11:7]] = wd;
        m_pc = nxt;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0;
            for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if (u_dut.r_pc !== m_pc) begin
            n_fail++;
            $display("FAIL model_pc t=%0t got=%h exp=%h", $time, u_dut.r_pc, m_pc);
        end
        n_tests++;
        cmp_bad = -1;
        for (int i = 31; i >= 0; i--) if (u_dut.u_idecode.RF.R[i] !== m_x[i]) cmp_bad = i;
        if (cmp_bad >= 0) begin
            n_fail++;
            $display("FAIL model_rf t=%0t x%0d got=%h exp=%h", $time, cmp_bad,
                     u_dut.u_idecode.RF.R[cmp_bad], m_x[cmp_bad]);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 32; i++) begin
            m_imem[i] = 32'h0;
            u_dut.u_imem.WORD.MEM[i] = 32'h0;
        end
    endtask

    task automatic put(input int idx, input logic [31:0] ins);
        m_imem[idx] = ins;
        u_dut.u_imem.WORD.MEM[idx] = ins;
    endtask

    task automatic reset_run(input int n);
        @(negedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic load_arith();
        clear_imem();
        put(0, enc_i(5, 0, 0, 1, 7'h13));
        put(1, enc_i(-7, 1, 0, 2, 7'h13));
        put(2, enc_i(3, 1, 1, 3, 7'h13));
        put(3, enc_i(32'h400 | 1, 2, 5, 4, 7'h13));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h0;
        clear_imem();

        // Reset, then all-zero IMEM executes as NOPs.
        @(negedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pc", u_dut.r_pc, 32'h0);
        check("reset_x5", u_dut.u_idecode.RF.R[5], 32'h0);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("nop_pc", u_dut.r_pc, 32'd20);
        check("nop_x31", u_dut.u_idecode.RF.R[31], 32'h0);

        load_arith();
        reset_run(6);
        check("addi_x1", u_dut.u_idecode.RF.R[1], 32'd5);
        check("addi_x2", u_dut.u_idecode.RF.R[2], 32'hFFFF_FFFE);
        check("slli_x3", u_dut.u_idecode.RF.R[3], 32'd40);
        check("srai_x4", u_dut.u_idecode.RF.R[4], 32'hFFFF_FFFF);

        put(4, enc_i(32'h7F, 0, 0, 5, 7'h13));
        put(5, enc_s(8, 5, 0, 2));
        put(6, enc_s(12, 2, 0, 0));
        put(7, enc_i(8, 0, 2, 6, 7'h03));
        put(8, enc_i(12, 0, 0, 7, 7'h03));
        put(9, enc_i(12, 0, 4, 8, 7'h03));
        reset_run(11);
        check("lw_x6", u_dut.u_idecode.RF.R[6], 32'd127);
        check("lb_x7", u_dut.u_idecode.RF.R[7], 32'hFFFF_FFFE);
        check("lbu_x8", u_dut.u_idecode.RF.R[8], 32'd254);

        clear_imem();
        put(0, enc_j(12, 1));
        put(1, enc_i(1, 0, 0, 10, 7'h13));
        put(2, enc_i(1, 0, 0, 10, 7'h13));
        put(3, enc_i(3, 0, 0, 11, 7'h13));
        put(4, enc_i(0, 1, 0, 0, 7'h67));
        reset_run(3);
        check("jal_x1", u_dut.u_idecode.RF.R[1], 32'd4);
        check("jal_x11", u_dut.u_idecode.RF.R[11], 32'd3);
        check("jal_skip_x10", u_dut.u_idecode.RF.R[10], 32'd0);
        check("jalr_pc", u_dut.r_pc, 32'd4);

        clear_imem();
        put(0, enc_i(5, 0, 0, 1, 7'h13));
        put(1, enc_i(-2, 0, 0, 2, 7'h13));
        put(2, enc_b(8, 1, 2, 0));
        put(3, enc_i(1, 0, 0, 12, 7'h13));
        put(4, enc_b(8, 2, 1, 4));
        put(5, enc_i(1, 0, 0, 13, 7'h13));
        put(6, enc_b(8, 2, 1, 6));
        put(7, enc_i(1, 0, 0, 14, 7'h13));
        put(8, enc_i(9, 0, 0, 0, 7'h13));
        put(9, enc_b(8, 1, 2, 1));
        put(10, enc_i(7, 0, 0, 13, 7'h13));
        put(11, enc_b(8, 2, 1, 7));
        put(12, enc_i(8, 0, 0, 13, 7'h13));
        put(13, enc_i(2, 0, 0, 15, 7'h13));
        reset_run(11);
        check("beq_fall_x12", u_dut.u_idecode.RF.R[12], 32'd1);
        check("blt_skip_x13", u_dut.u_idecode.RF.R[13], 32'd0);
        check("bltu_fall_x14", u_dut.u_idecode.RF.R[14], 32'd1);
        check("x0_zero", u_dut.u_idecode.RF.R[0], 32'd0);
        check("bgeu_tgt_x15", u_dut.u_idecode.RF.R[15], 32'd2);

        clear_imem();
        put(0, enc_i(5, 0, 0, 1, 7'h13));
        put(1, enc_i(-2, 0, 0, 2, 7'h13));
        put(2, enc_r(0, 2, 1, 0, 15));
        put(3, enc_r(32, 1, 2, 0, 16));
        put(4, enc_r(0, 2, 1, 3, 17));
        put(5, enc_r(0, 1, 2, 2, 18));
        put(6, enc_r(32, 1, 2, 5, 19));
        put(7, enc_r(0, 1, 2, 5, 20));
        put(8, enc_u(32'h12345, 21, 7'h37));
        put(9, enc_u(1, 22, 7'h17));
        put(10, enc_s(16, 0, 0, 2));
        put(11, enc_s(16, 2, 0, 1));
        put(12, enc_s(18, 1, 0, 0));
        put(13, enc_i(16, 0, 1, 23, 7'h03));
        put(14, enc_i(17, 0, 5, 24, 7'h03));
        put(15, enc_i(16, 0, 2, 25, 7'h03));
        put(16, enc_i(18, 0, 0, 26, 7'h03));
        put(17, enc_i(15, 2, 4, 27, 7'h13));
        put(18, enc_i(-1, 1, 3, 29, 7'h13));
        reset_run(19);
        check("add_x15", u_dut.u_idecode.RF.R[15], 32'd3);
        check("sub_x16", u_dut.u_idecode.RF.R[16], 32'hFFFF_FFF9);
        check("sltu_x17", u_dut.u_idecode.RF.R[17], 32'd1);
        check("slt_x18", u_dut.u_idecode.RF.R[18], 32'd1);
        check("sra_x19", u_dut.u_idecode.RF.R[19], 32'hFFFF_FFFF);
        check("srl_x20", u_dut.u_idecode.RF.R[20], 32'h07FF_FFFF);
        check("lui_x21", u_dut.u_idecode.RF.R[21], 32'h1234_5000);
        check("auipc_x22", u_dut.u_idecode.RF.R[22], 32'h0000_1024);
        check("lh_x23", u_dut.u_idecode.RF.R[23], 32'hFFFF_FFFE);
        check("lhu_mis_x24", u_dut.u_idecode.RF.R[24], 32'h0000_FFFE);
        check("lw_x25", u_dut.u_idecode.RF.R[25], 32'h0005_FFFE);
        check("lb_x26", u_dut.u_idecode.RF.R[26], 32'd5);
        check("xori_x27", u_dut.u_idecode.RF.R[27], 32'hFFFF_FFF1);
        check("sltiu_x29", u_dut.u_idecode.RF.R[29], 32'd1);

        // Reset pulsed after three instructions, then a clean rerun.
        load_arith();
        reset_run(3);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_x1", u_dut.u_idecode.RF.R[1], 32'd0);
        check("midrst_pc", u_dut.r_pc, 32'd0);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rerun_x1", u_dut.u_idecode.RF.R[1], 32'd5);
        check("rerun_x2", u_dut.u_idecode.RF.R[2], 32'hFFFF_FFFE);
        check("rerun_x3", u_dut.u_idecode.RF.R[3], 32'd40);
        check("rerun_x4", u_dut.u_idecode.RF.R[4], 32'hFFFF_FFFF);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
